// File: rtl/sa_w_sched_if.sv
// rtl/sa_w_sched_if.sv - use-bit, miss-fill and status-array write port bundle
interface sa_w_sched_if #(
   parameter int SET_ADDR_WIDTH = 4,
   parameter int SA_WORD_WIDTH  = 8,
   parameter int NUM_WAYS       = 4,
   parameter int UQ_DEPTH       = 2
);
   localparam int CW = $clog2(UQ_DEPTH + 1);

   logic [SET_ADDR_WIDTH-1:0] i_ubit_upd_sa_set_addr;
   logic [SA_WORD_WIDTH-1:0]  i_ubit_upd_sa_data;
   logic [NUM_WAYS-1:0]       i_ubit_upd_sa_mask;
   logic                      i_ubit_upd_sa_valid;
   logic                      o_ubit_upd_ready;
   logic [SET_ADDR_WIDTH-1:0] i_miss_write_set_addr;
   logic [SA_WORD_WIDTH-1:0]  i_miss_write_data;
   logic [NUM_WAYS-1:0]       i_miss_write_mask;
   logic                      i_miss_if_valid;
   logic                      i_miss_state;
   logic [SET_ADDR_WIDTH-1:0] o_w_set_addr;
   logic [SA_WORD_WIDTH-1:0]  o_w_data;
   logic [NUM_WAYS-1:0]       o_w_mask;
   logic                      o_w_valid;
   logic [CW-1:0]             o_uq_count;

   modport master (
      output i_ubit_upd_sa_set_addr, i_ubit_upd_sa_data, i_ubit_upd_sa_mask, i_ubit_upd_sa_valid,
      output i_miss_write_set_addr, i_miss_write_data, i_miss_write_mask, i_miss_if_valid,
      output i_miss_state,
      input  o_ubit_upd_ready, o_w_set_addr, o_w_data, o_w_mask, o_w_valid, o_uq_count
   );

   modport slave (
      input  i_ubit_upd_sa_set_addr, i_ubit_upd_sa_data, i_ubit_upd_sa_mask, i_ubit_upd_sa_valid,
      input  i_miss_write_set_addr, i_miss_write_data, i_miss_write_mask, i_miss_if_valid,
      input  i_miss_state,
      output o_ubit_upd_ready, o_w_set_addr, o_w_data, o_w_mask, o_w_valid, o_uq_count
   );
endinterface

// File: rtl/sa_w_sched.sv
// rtl/sa_w_sched.sv - status-array write scheduler: miss fills win, use-bit updates queue and merge per set
module sa_w_sched #(
   parameter int SET_ADDR_WIDTH = 4,
   parameter int SA_WORD_WIDTH  = 8,
   parameter int NUM_WAYS       = 4,
   parameter int UQ_DEPTH       = 2
) (
   input logic         clk,
   input logic         reset,
   sa_w_sched_if.slave bus
);
   localparam int CW  = $clog2(UQ_DEPTH + 1);
   localparam int BPW = SA_WORD_WIDTH / NUM_WAYS;

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DRAIN} state_t;

   state_t                    state;
   logic [SET_ADDR_WIDTH-1:0] q_set  [UQ_DEPTH];
   logic [SA_WORD_WIDTH-1:0]  q_data [UQ_DEPTH];
   logic [NUM_WAYS-1:0]       q_mask [UQ_DEPTH];
   logic [CW-1:0]             q_count;

   logic [SET_ADDR_WIDTH-1:0] h_set  [UQ_DEPTH];
   logic [SA_WORD_WIDTH-1:0]  h_data [UQ_DEPTH];
   logic [NUM_WAYS-1:0]       h_mask [UQ_DEPTH];
   logic [SET_ADDR_WIDTH-1:0] n_set  [UQ_DEPTH];
   logic [SA_WORD_WIDTH-1:0]  n_data [UQ_DEPTH];
   logic [NUM_WAYS-1:0]       n_mask [UQ_DEPTH];
   logic [CW-1:0]             h_cnt, p_cnt, n_cnt, hit_idx;
   logic [NUM_WAYS-1:0]       hz_mask;
   logic                      ready, acc, pass, enq, pop, hit;

   function automatic logic [SA_WORD_WIDTH-1:0] merge_word(
      input logic [SA_WORD_WIDTH-1:0] old_w,
      input logic [SA_WORD_WIDTH-1:0] new_w,
      input logic [NUM_WAYS-1:0]      mask
   );
      logic [SA_WORD_WIDTH-1:0] r;
      r = old_w;
      for (int w = 0; w < NUM_WAYS; w++)
         if (mask[w]) r[w*BPW +: BPW] = new_w[w*BPW +: BPW];
      return r;
   endfunction

   assign ready                = q_count < CW'(UQ_DEPTH);
   assign bus.o_ubit_upd_ready = ready;
   assign bus.o_uq_count       = q_count;

   always_comb begin
      // Hazard clear and compaction: stale use-bits for a set being filled lose the filled ways.
      h_cnt   = '0;
      hz_mask = '0;
      for (int i = 0; i < UQ_DEPTH; i++) begin
         h_set[i]  = '0;
         h_data[i] = '0;
         h_mask[i] = '0;
      end
      for (int i = 0; i < UQ_DEPTH; i++) begin
         hz_mask = q_mask[i];
         if (bus.i_miss_if_valid && q_set[i] == bus.i_miss_write_set_addr)
            hz_mask = hz_mask & ~bus.i_miss_write_mask;
         if (CW'(i) < q_count && hz_mask != '0) begin
            for (int j = 0; j < UQ_DEPTH; j++) begin
               if (CW'(j) == h_cnt) begin
                  h_set[j]  = q_set[i];
                  h_data[j] = q_data[i];
                  h_mask[j] = hz_mask;
               end
            end
            h_cnt = h_cnt + CW'(1);
         end
      end

      pop = (state == S_DRAIN) && !bus.i_miss_state && !bus.i_miss_if_valid && (h_cnt != '0);
      for (int i = 0; i < UQ_DEPTH - 1; i++) begin
         n_set[i]  = pop ? h_set[i+1]  : h_set[i];
         n_data[i] = pop ? h_data[i+1] : h_data[i];
         n_mask[i] = pop ? h_mask[i+1] : h_mask[i];
      end
      n_set[UQ_DEPTH-1]  = pop ? '0 : h_set[UQ_DEPTH-1];
      n_data[UQ_DEPTH-1] = pop ? '0 : h_data[UQ_DEPTH-1];
      n_mask[UQ_DEPTH-1] = pop ? '0 : h_mask[UQ_DEPTH-1];
      p_cnt = pop ? h_cnt - CW'(1) : h_cnt;

      acc  = bus.i_ubit_upd_sa_valid && ready && (bus.i_ubit_upd_sa_mask != '0);
      pass = acc && (state == S_IDLE) && !bus.i_miss_state && !bus.i_miss_if_valid;
      enq  = acc && !pass;

      // The entry being popped this cycle is no longer a merge target.
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < UQ_DEPTH; i++) begin
         if (CW'(i) < p_cnt && n_set[i] == bus.i_ubit_upd_sa_set_addr) begin
            hit     = 1'b1;
            hit_idx = CW'(i);
         end
      end
      for (int i = 0; i < UQ_DEPTH; i++) begin
         if (enq && hit && CW'(i) == hit_idx) begin
            n_mask[i] = n_mask[i] | bus.i_ubit_upd_sa_mask;
            n_data[i] = merge_word(n_data[i], bus.i_ubit_upd_sa_data, bus.i_ubit_upd_sa_mask);
         end else if (enq && !hit && CW'(i) == p_cnt) begin
            n_set[i]  = bus.i_ubit_upd_sa_set_addr;
            n_data[i] = bus.i_ubit_upd_sa_data;
            n_mask[i] = bus.i_ubit_upd_sa_mask;
         end
      end
      n_cnt = (enq && !hit) ? p_cnt + CW'(1) : p_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         q_count          <= '0;
         bus.o_w_valid    <= 1'b0;
         bus.o_w_set_addr <= '0;
         bus.o_w_data     <= '0;
         bus.o_w_mask     <= '0;
         for (int i = 0; i < UQ_DEPTH; i++) begin
            q_set[i]  <= '0;
            q_data[i] <= '0;
            q_mask[i] <= '0;
         end
      end else begin
         q_count <= n_cnt;
         for (int i = 0; i < UQ_DEPTH; i++) begin
            q_set[i]  <= n_set[i];
            q_data[i] <= n_data[i];
            q_mask[i] <= n_mask[i];
         end
         bus.o_w_valid <= bus.i_miss_if_valid | pop | pass;
         if (bus.i_miss_if_valid) begin
            bus.o_w_set_addr <= bus.i_miss_write_set_addr;
            bus.o_w_data     <= bus.i_miss_write_data;
            bus.o_w_mask     <= bus.i_miss_write_mask;
         end else if (pop) begin
            bus.o_w_set_addr <= h_set[0];
            bus.o_w_data     <= h_data[0];
            bus.o_w_mask     <= h_mask[0];
         end else if (pass) begin
            bus.o_w_set_addr <= bus.i_ubit_upd_sa_set_addr;
            bus.o_w_data     <= bus.i_ubit_upd_sa_data;
            bus.o_w_mask     <= bus.i_ubit_upd_sa_mask;
         end
         case (state)
            S_IDLE, S_HOLD, S_DRAIN: begin
               if (bus.i_miss_state)  state <= S_HOLD;
               else if (n_cnt != '0)  state <= S_DRAIN;
               else                   state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sa_w_sched.sv
// tb/tb_sa_w_sched.sv - randomized and directed bench for sa_w_sched against a queue-based reference
module tb_sa_w_sched;
   localparam int DEPTH = 2;

   typedef struct {
      logic [3:0] set;
      logic [7:0] data;
      logic [3:0] mask;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   int   nchk = 0;
   int   npass = 0;

   ent_t       mq[$];
   int         mst;
   logic       e_valid;
   logic [3:0] e_set;
   logic [7:0] e_data;
   logic [3:0] e_mask;
   logic [7:0] sa_ref [16];
   logic [7:0] sa_dut [16];

   localparam int M_IDLE = 0, M_HOLD = 1, M_DRAIN = 2;

   sa_w_sched_if #(.SET_ADDR_WIDTH(4), .SA_WORD_WIDTH(8), .NUM_WAYS(4), .UQ_DEPTH(DEPTH)) bus ();

   sa_w_sched #(.SET_ADDR_WIDTH(4), .SA_WORD_WIDTH(8), .NUM_WAYS(4), .UQ_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] apply_ways(input logic [7:0] old_w, input logic [7:0] new_w,
                                             input logic [3:0] mask);
      logic [7:0] r;
      r = old_w;
      for (int w = 0; w < 4; w++)
         if (mask[w]) r[2*w +: 2] = new_w[2*w +: 2];
      return r;
   endfunction

   task automatic model_step();
      ent_t e;
      int   hit;
      bit   rdy;
      if (reset) begin
         mq.delete();
         mst = M_IDLE;
         e_valid = 0; e_set = 0; e_data = 0; e_mask = 0;
         return;
      end
      rdy = mq.size() < DEPTH;
      e_valid = 0;
      if (bus.i_miss_if_valid) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].set == bus.i_miss_write_set_addr) begin
               e = mq[i];
               e.mask = e.mask & ~bus.i_miss_write_mask;
               if (e.mask == 0) mq.delete(i);
               else mq[i] = e;
            end
         end
         e_valid = 1; e_set = bus.i_miss_write_set_addr;
         e_data = bus.i_miss_write_data; e_mask = bus.i_miss_write_mask;
      end else if (mst == M_DRAIN && !bus.i_miss_state && mq.size() != 0) begin
         e = mq.pop_front();
         e_valid = 1; e_set = e.set; e_data = e.data; e_mask = e.mask;
      end
      if (bus.i_ubit_upd_sa_valid && rdy && bus.i_ubit_upd_sa_mask != 0) begin
         if (mst == M_IDLE && !bus.i_miss_state && !bus.i_miss_if_valid) begin
            e_valid = 1; e_set = bus.i_ubit_upd_sa_set_addr;
            e_data = bus.i_ubit_upd_sa_data; e_mask = bus.i_ubit_upd_sa_mask;
         end else begin
            hit = -1;
            for (int i = 0; i < mq.size(); i++)
               if (mq[i].set == bus.i_ubit_upd_sa_set_addr) hit = i;
            if (hit >= 0) begin
               e = mq[hit];
               e.data = apply_ways(e.data, bus.i_ubit_upd_sa_data, bus.i_ubit_upd_sa_mask);
               e.mask = e.mask | bus.i_ubit_upd_sa_mask;
               mq[hit] = e;
            end else begin
               e.set = bus.i_ubit_upd_sa_set_addr; e.data = bus.i_ubit_upd_sa_data;
               e.mask = bus.i_ubit_upd_sa_mask;
               mq.push_back(e);
            end
         end
      end
      if (bus.i_miss_state) mst = M_HOLD;
      else if (mq.size() != 0) mst = M_DRAIN;
      else mst = M_IDLE;
   endtask

   task automatic step(input bit rst, input bit uv, input logic [3:0] us, input logic [7:0] ud,
                       input logic [3:0] um, input bit mv, input logic [3:0] mset,
                       input logic [7:0] md, input logic [3:0] mm, input bit ms);
      reset = rst;
      bus.i_ubit_upd_sa_valid = uv; bus.i_ubit_upd_sa_set_addr = us;
      bus.i_ubit_upd_sa_data = ud;  bus.i_ubit_upd_sa_mask = um;
      bus.i_miss_if_valid = mv;     bus.i_miss_write_set_addr = mset;
      bus.i_miss_write_data = md;   bus.i_miss_write_mask = mm;
      bus.i_miss_state = ms;
      if (!rst) chk("ready", bus.o_ubit_upd_ready, 32'(mq.size() < DEPTH));
      model_step();
      @(posedge clk);
      #1;
      chk("w_valid", bus.o_w_valid, e_valid);
      chk("w_set", bus.o_w_set_addr, e_set);
      chk("w_data", bus.o_w_data, e_data);
      chk("w_mask", bus.o_w_mask, e_mask);
      chk("uq_count", bus.o_uq_count, mq.size());
      if (e_valid) sa_ref[e_set] = apply_ways(sa_ref[e_set], e_data, e_mask);
      if (bus.o_w_valid === 1'b1) sa_dut[bus.o_w_set_addr] = apply_ways(sa_dut[bus.o_w_set_addr], bus.o_w_data, bus.o_w_mask);
   endtask

   task automatic idle(input bit ms);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, ms);
   endtask

   task automatic ubit(input logic [3:0] s, input logic [7:0] d, input logic [3:0] m, input bit ms);
      step(0, 1, s, d, m, 0, 0, 0, 0, ms);
   endtask

   task automatic miss(input logic [3:0] s, input logic [7:0] d, input logic [3:0] m, input bit ms);
      step(0, 0, 0, 0, 0, 1, s, d, m, ms);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         sa_ref[i] = 0;
         sa_dut[i] = 0;
      end
      mst = M_IDLE;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 1: direct pass-through
      ubit(3, 8'h40, 4'b1000, 0);
      chk("t1_valid", bus.o_w_valid, 1);
      chk("t1_word", {bus.o_w_set_addr, bus.o_w_data, bus.o_w_mask}, {4'd3, 8'h40, 4'b1000});
      idle(0);

      // 2: queue under miss, drain in order
      ubit(5, 8'h01, 4'b0001, 1);
      ubit(9, 8'h02, 4'b0001, 1);
      chk("t2_cnt", bus.o_uq_count, 2);
      chk("t2_ready", bus.o_ubit_upd_ready, 0);
      idle(0);
      idle(0);
      chk("t2_first", {bus.o_w_valid, bus.o_w_set_addr}, {1'b1, 4'd5});
      idle(0);
      chk("t2_second", {bus.o_w_valid, bus.o_w_set_addr}, {1'b1, 4'd9});
      idle(0);
      chk("t2_done", bus.o_w_valid, 0);

      // 3: merge in HOLD
      ubit(5, 8'h01, 4'b0001, 1);
      ubit(5, 8'h0C, 4'b0010, 1);
      chk("t3_cnt", bus.o_uq_count, 1);
      idle(0);
      idle(0);
      chk("t3_word", {bus.o_w_valid, bus.o_w_set_addr, bus.o_w_data, bus.o_w_mask},
          {1'b1, 4'd5, 8'h0D, 4'b0011});
      idle(0);

      // 4: hazard clear, partial then full
      ubit(7, 8'h3C, 4'b0110, 1);
      miss(7, 8'hAA, 4'b0100, 1);
      idle(0);
      idle(0);
      chk("t4_partial", {bus.o_w_set_addr, bus.o_w_mask}, {4'd7, 4'b0010});
      idle(0);
      ubit(7, 8'h3C, 4'b0110, 1);
      miss(7, 8'h55, 4'b0100, 1);
      miss(7, 8'h55, 4'b0010, 1);
      chk("t4_removed", bus.o_uq_count, 0);
      idle(0);

      // 5: miss and use-bit collide in IDLE
      step(0, 1, 4, 8'hC0, 4'b1000, 1, 2, 8'h11, 4'b1111, 0);
      chk("t5_miss", {bus.o_w_valid, bus.o_w_set_addr}, {1'b1, 4'd2});
      chk("t5_cnt", bus.o_uq_count, 1);
      idle(0);
      chk("t5_ubit", {bus.o_w_valid, bus.o_w_set_addr}, {1'b1, 4'd4});
      idle(0);

      // 6: reset while draining
      ubit(1, 8'h03, 4'b0001, 1);
      ubit(2, 8'h0C, 4'b0010, 1);
      idle(0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_valid", bus.o_w_valid, 0);
      chk("t6_cnt", bus.o_uq_count, 0);
      chk("t6_ready", bus.o_ubit_upd_ready, 1);
      idle(0);

      begin
         bit ms = 0;
         for (int n = 0; n < 3000; n++) begin
            bit rst, uv, mv;
            if ($urandom_range(7) == 0) ms = ~ms;
            rst = ($urandom_range(199) == 0);
            uv  = ($urandom_range(1) == 0);
            mv  = ($urandom_range(3) == 0);
            step(rst, uv, 4'($urandom_range(3)), 8'($urandom), 4'($urandom),
                 mv, 4'($urandom_range(3)), 8'($urandom), 4'($urandom), ms);
         end
      end
      for (int i = 0; i < 16; i++) chk("sa_word", sa_dut[i], sa_ref[i]);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
